// File: rtl/cdc_hs_pkg.sv
// Shared state type, default parameters and sizing helper for the handshake source.
package cdc_hs_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } cdc_hs_state_e;

    localparam int unsigned DefaultDw       = 32;
    localparam int unsigned DefaultNsync    = 2;
    localparam int unsigned DefaultToCycles = 1023;

    // Counter width able to represent 0..cycles inclusive.
    function automatic int unsigned to_cnt_width(input int unsigned cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/cdc_hs_src_sync.sv
// Multi-flop level synchronizer for a single asynchronous bit, reset to 0.
module cdc_hs_src_sync
    import cdc_hs_pkg::*;
#(
    parameter int unsigned NSYNC = DefaultNsync
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [NSYNC-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[NSYNC-2:0], d};
        end
    end

    assign q = sync_q[NSYNC-1];

endmodule

// File: rtl/cdc_hs_src.sv
// Source side of a 4-phase req/ack clock-domain crossing with registered payload.
// Define CDC_HS_TIMEOUT_EN to add the handshake timeout counter and sticky err_timeout.
module cdc_hs_src
    import cdc_hs_pkg::*;
#(
    parameter int unsigned DW        = DefaultDw,
    parameter int unsigned NSYNC     = DefaultNsync,
    parameter int unsigned TO_CYCLES = DefaultToCycles
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          x_req,
    output logic [DW-1:0] x_data,
    input  logic          x_ack,
    output logic          busy,
    input  logic          err_clr,
    output logic          err_timeout
);

    cdc_hs_state_e state_q, state_d;
    logic          ack_s;
    logic          xfer;
    logic          timeout;
    logic          x_req_q, x_req_d;
    logic [DW-1:0] x_data_q, x_data_d;

    cdc_hs_src_sync #(
        .NSYNC(NSYNC)
    ) u_ack_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (x_ack),
        .q    (ack_s)
    );

    assign xfer = s_valid && s_ready;

`ifdef CDC_HS_TIMEOUT_EN
    localparam int unsigned CntW = to_cnt_width(TO_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(TO_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;

    // Fires on the edge that would bring the count of busy cycles up to TO_CYCLES.
    assign timeout = (state_q != IDLE) && (cnt_q == CntLast);

    always_comb begin
        cnt_d = '0;
        if (state_q != IDLE && state_d == state_q) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Set has priority over clear.
    always_comb begin
        err_d = err_q;
        if (timeout) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err_timeout = err_q;
`else
    localparam int unsigned unused_to_cycles = TO_CYCLES;
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign timeout        = 1'b0;
    assign err_timeout    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            x_req_q  <= 1'b0;
            x_data_q <= '0;
        end else begin
            state_q  <= state_d;
            x_req_q  <= x_req_d;
            x_data_q <= x_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (xfer)   state_d = REQ;
            REQ:     if (ack_s)  state_d = RELEASE;
            RELEASE: if (!ack_s) state_d = IDLE;
            default:             state_d = IDLE;
        endcase
        if (timeout) begin
            state_d = IDLE;
        end
    end

    // Payload only loads on acceptance, so it holds for the whole handshake.
    always_comb begin
        x_req_d  = x_req_q;
        x_data_d = x_data_q;
        if (state_q == IDLE && xfer) begin
            x_req_d  = 1'b1;
            x_data_d = s_data;
        end else if (state_q == REQ && ack_s) begin
            x_req_d = 1'b0;
        end
        if (timeout) begin
            x_req_d = 1'b0;
        end
    end

    always_comb begin
        s_ready = (state_q == IDLE) && !ack_s;
        busy    = (state_q != IDLE);
    end

    assign x_req  = x_req_q;
    assign x_data = x_data_q;

endmodule

// File: tb/tb_cdc_hs_src.sv
// Bench for cdc_hs_src: directed vector table, corner sequences, and a randomized
// run against a cycle-count model of the 4-phase handshake with a delayed-echo destination.
module tb_cdc_hs_src;

    localparam int unsigned DW        = 32;
    localparam int unsigned NSYNC     = 2;
    localparam int unsigned TO_CYCLES = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          x_req;
    logic [DW-1:0] x_data;
    logic          x_ack;
    logic          busy;
    logic          err_clr;
    logic          err_timeout;

    // Destination model: echo x_req after dly clk edges, or drive a forced level.
    logic          ack_echo;
    logic          ack_force;
    logic [1:0]    dly;
    logic [2:0]    xr_sh;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct {
        logic          echo;
        logic          ack;
        logic          v;
        logic [DW-1:0] d;
        logic          rdy;
        logic          req;
        logic          bsy;
        logic [DW-1:0] data;
    } vec_t;

    vec_t          tbl[19];
    logic [DW-1:0] got[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_data;
    logic [DW-1:0] want;
    logic          prev_req;
    logic          acc;
    logic          go;
    int            sent;
    int            last_acc;
    int            rel;
    int            rt;
    int            hold;

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) xr_sh <= '0;
        else        xr_sh <= {xr_sh[1:0], x_req};
    end

    assign x_ack = !ack_echo ? ack_force : (dly == 2'd0) ? x_req : xr_sh[dly - 2'd1];

    cdc_hs_src #(
        .DW       (DW),
        .NSYNC    (NSYNC),
        .TO_CYCLES(TO_CYCLES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .x_req      (x_req),
        .x_data     (x_data),
        .x_ack      (x_ack),
        .busy       (busy),
        .err_clr    (err_clr),
        .err_timeout(err_timeout)
    );

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic chk_word(input string name, input logic [DW-1:0] act,
                            input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'hDEADBEEF};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 32'h55,       1'b0, 1'b1, 1'b1, 32'hDEADBEEF};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'hDEADBEEF};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'hDEADBEEF};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'hDEADBEEF};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'hDEADBEEF};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'hDEADBEEF};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'hDEADBEEF};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 32'h77,       1'b0, 1'b0, 1'b0, 32'hDEADBEEF};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 32'h77,       1'b0, 1'b0, 1'b0, 32'hDEADBEEF};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'hDEADBEEF};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b1, 1'b1, 32'hA5A5A5A5};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'hA5A5A5A5};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'hA5A5A5A5};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'hA5A5A5A5};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'hA5A5A5A5};
        tbl[17] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'hA5A5A5A5};
        tbl[18] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'hA5A5A5A5};

        // Reset with a stale ack held high by the destination.
        rst_n     = 1'b0;
        s_valid   = 1'b0;
        s_data    = '0;
        err_clr   = 1'b0;
        ack_echo  = 1'b0;
        ack_force = 1'b1;
        dly       = 2'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_bit ("rst_s_ready", s_ready, 1'b1);
        chk_bit ("rst_x_req", x_req, 1'b0);
        chk_bit ("rst_busy", busy, 1'b0);
        chk_word("rst_x_data", x_data, '0);
        chk_bit ("rst_err", err_timeout, 1'b0);

        for (int i = 1; i <= 5; i++) begin
            step();
            chk_bit("stale_hold", s_ready, (i < int'(NSYNC)));
            chk_bit("stale_busy", busy, 1'b0);
        end
        ack_force = 1'b0;
        for (int i = 1; i <= int'(NSYNC); i++) begin
            step();
            chk_bit("stale_release", s_ready, (i == int'(NSYNC)));
        end

        // Directed vectors: single transfer, ignored mid-REQ pulse, stale ack in IDLE.
        for (int i = 0; i < 19; i++) begin
            ack_echo  = tbl[i].echo;
            ack_force = tbl[i].ack;
            s_valid   = tbl[i].v;
            s_data    = tbl[i].d;
            step();
            chk_bit ($sformatf("vec%0d_s_ready", i), s_ready, tbl[i].rdy);
            chk_bit ($sformatf("vec%0d_x_req", i), x_req, tbl[i].req);
            chk_bit ($sformatf("vec%0d_busy", i), busy, tbl[i].bsy);
            chk_word($sformatf("vec%0d_x_data", i), x_data, tbl[i].data);
        end
        s_valid   = 1'b0;
        ack_echo  = 1'b1;
        ack_force = 1'b0;

        // Back-to-back with s_valid held: destination sees each payload exactly once.
        got.delete();
        prev_req = x_req;
        sent     = 0;
        s_valid  = 1'b1;
        s_data   = 32'h1;
        for (int i = 0; i < 40; i++) begin
            acc = s_valid && s_ready;
            step();
            if (x_req && !prev_req) got.push_back(x_data);
            prev_req = x_req;
            if (acc) begin
                sent++;
                if (sent == 3) s_valid = 1'b0;
                else           s_data  = DW'(sent + 1);
            end
        end
        s_valid = 1'b0;
        chk_word("b2b_count", DW'(got.size()), DW'(3));
        for (int k = 0; k < 3; k++) begin
            want = DW'(k + 1);
            chk_word($sformatf("b2b_item%0d", k), (k < got.size()) ? got[k] : '0, want);
        end

`ifdef CDC_HS_TIMEOUT_EN
        // Destination never answers: timeout fires TO_CYCLES edges after entering REQ.
        ack_echo  = 1'b0;
        ack_force = 1'b0;
        s_valid   = 1'b1;
        s_data    = 32'hC0FFEE00;
        step();
        s_valid = 1'b0;
        for (int i = 1; i < int'(TO_CYCLES); i++) begin
            step();
            chk_bit("to_wait_err", err_timeout, 1'b0);
            chk_bit("to_wait_req", x_req, 1'b1);
        end
        step();
        chk_bit ("to_err", err_timeout, 1'b1);
        chk_bit ("to_x_req", x_req, 1'b0);
        chk_bit ("to_busy", busy, 1'b0);
        chk_bit ("to_s_ready", s_ready, 1'b1);
        chk_word("to_x_data", x_data, 32'hC0FFEE00);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk_bit("to_clear", err_timeout, 1'b0);

        // Clear held across a second timeout: the set must win on the timeout edge.
        s_valid = 1'b1;
        s_data  = 32'h0BADF00D;
        step();
        s_valid = 1'b0;
        err_clr = 1'b1;
        for (int i = 1; i < int'(TO_CYCLES); i++) step();
        step();
        chk_bit("to_set_wins", err_timeout, 1'b1);
        step();
        err_clr = 1'b0;
        chk_bit("to_clear2", err_timeout, 1'b0);
        ack_echo = 1'b1;
`else
        // Without the timeout the FSM waits indefinitely and the flag stays low.
        ack_echo  = 1'b0;
        ack_force = 1'b0;
        s_valid   = 1'b1;
        s_data    = 32'hC0FFEE00;
        step();
        s_valid = 1'b0;
        repeat (12) step();
        chk_bit ("noto_x_req", x_req, 1'b1);
        chk_bit ("noto_busy", busy, 1'b1);
        chk_bit ("noto_err", err_timeout, 1'b0);
        chk_word("noto_x_data", x_data, 32'hC0FFEE00);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk_bit("noto_err_clr", err_timeout, 1'b0);
        ack_echo = 1'b1;
        repeat (10) step();
        chk_bit("noto_done_busy", busy, 1'b0);
        chk_bit("noto_done_ready", s_ready, 1'b1);
`endif

        // Asynchronous reset while in RELEASE.
        dly     = 2'd0;
        s_valid = 1'b1;
        s_data  = 32'h12345678;
        step();
        s_valid = 1'b0;
        repeat (4) step();
        chk_bit("rel_busy", busy, 1'b1);
        chk_bit("rel_x_req", x_req, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_bit ("arst_x_req", x_req, 1'b0);
        chk_bit ("arst_busy", busy, 1'b0);
        chk_word("arst_x_data", x_data, '0);
        chk_bit ("arst_s_ready", s_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic against the handshake timing model.
        exp_data = '0;
        last_acc = cyc - 100;
        for (int ph = 0; ph < 4; ph++) begin
            dly      = 2'($urandom_range(0, 3));
            ack_echo = 1'b1;
            rt       = 2 * (int'(dly) + int'(NSYNC)) + 2;
            hold     = int'(dly) + int'(NSYNC);
            exp_q.delete();
            prev_req = x_req;
            for (int i = 0; i < 92; i++) begin
                rel = cyc - last_acc;
                chk_bit ("rnd_s_ready", s_ready, (rel >= rt));
                chk_bit ("rnd_x_req", x_req, (rel <= hold));
                chk_bit ("rnd_busy", busy, (rel < rt));
                chk_word("rnd_x_data", x_data, exp_data);
                if (x_req && !prev_req) begin
                    want = (exp_q.size() > 0) ? exp_q.pop_front() : ~x_data;
                    chk_word("rnd_order", x_data, want);
                end
                prev_req = x_req;
                s_valid  = (i < 80) && ($urandom_range(0, 2) != 0);
                s_data   = $urandom;
                go       = s_valid && (rel >= rt);
                step();
                if (go) begin
                    last_acc = cyc;
                    exp_data = s_data;
                    exp_q.push_back(s_data);
                end
            end
            chk_word("rnd_drained", DW'(exp_q.size()), '0);
        end
        s_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cdc_hs_src.md
CDC_HS_SRC -- requirements
Module: cdc_hs_src

Interface
REQ-001 Parameter DW, default 32, SHALL set the payload width in bits (DW >= 1).
REQ-002 Parameter NSYNC, default 2, SHALL set the ack synchronizer depth in flops (NSYNC >= 2).
REQ-003 Parameter TO_CYCLES, default 1023, SHALL set the handshake timeout in clk cycles (>= 1).
REQ-004 clk  in  1  source-domain clock; all logic SHALL be rising-edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 s_valid  in  1  source-side payload valid.
REQ-007 s_ready  out  1  payload accept; transfer occurs when s_valid && s_ready.
REQ-008 s_data  in  DW  source payload.
REQ-009 x_req  out  1  4-phase request to destination domain, registered output.
REQ-010 x_data  out  DW  crossing payload, registered output.
REQ-011 x_ack  in  1  4-phase acknowledge, asynchronous to clk.
REQ-012 busy  out  1  high whenever state != IDLE.
REQ-013 err_clr  in  1  synchronous clear of err_timeout.
REQ-014 err_timeout  out  1  sticky handshake-timeout flag.

Function
REQ-015 x_ack SHALL be sampled only through an NSYNC-stage synchronizer; the output is ack_s.
REQ-016 FSM states SHALL be IDLE, REQ, RELEASE.
REQ-017 s_ready SHALL be combinational: 1 iff state == IDLE && ack_s == 0.
REQ-018 IDLE: on transfer, x_data <= s_data, x_req <= 1, state -> REQ; x_req rises exactly 1 cycle after the accepting edge.
REQ-019 REQ: when ack_s == 1, x_req <= 0, state -> RELEASE.
REQ-020 RELEASE: when ack_s == 0, state -> IDLE; the next transfer may be accepted in that same IDLE cycle.
REQ-021 x_data SHALL remain stable from the capture edge until the FSM returns to IDLE.
REQ-022 s_valid while not in IDLE SHALL be ignored; s_data SHALL NOT be captured.
REQ-023 ack_s high in IDLE (stale ack) SHALL hold s_ready low until ack_s falls.
REQ-024 Minimum handshake round-trip, with ack echoed combinationally by the destination, SHALL be 2*NSYNC + 2 cycles from acceptance to the next s_ready.

Reset
REQ-025 Asserting rst_n low SHALL immediately force state = IDLE, x_req = 0, x_data = 0, err_timeout = 0, synchronizer flops = 0, and timeout counter = 0, regardless of the current state.
REQ-026 After reset release, s_ready SHALL be 1 once ack_s == 0.

Configuration
REQ-027 Macro CDC_HS_TIMEOUT_EN defined: a counter of width $clog2(TO_CYCLES+1) SHALL count cycles spent in REQ or RELEASE and clear on every state change.
REQ-028 With the macro defined, when the counter reaches TO_CYCLES: err_timeout <= 1, x_req <= 0, state -> IDLE (stale-ack gating per REQ-023 applies).
REQ-029 With the macro defined, err_clr SHALL clear err_timeout; if timeout and err_clr occur in the same cycle, set SHALL win.
REQ-030 Macro undefined: no counter SHALL be present, err_timeout SHALL be constant 0, and err_clr SHALL be ignored.

Structure
REQ-031 Package cdc_hs_pkg SHALL hold the state enum typedef (IDLE, REQ, RELEASE) and the default-parameter constants.
REQ-032 Ack synchronization SHALL instantiate the team's sync sub-module (NSYNC stages, reset to 0); no other sub-module is used.

Verification
REQ-033 Single transfer, DW=32, NSYNC=2, ack echoed from x_req: s_data=0xDEADBEEF -> x_req rises 1 cycle after acceptance, x_data=0xDEADBEEF held, s_ready returns after 6 cycles.
REQ-034 Back-to-back: s_valid held high with 0x1, 0x2, 0x3 -> exactly 3 transfers in order, none dropped or duplicated.
REQ-035 s_valid pulsed with 0x55 while in REQ -> not accepted, x_data unchanged.
REQ-036 Stale ack: x_ack held 1 out of reset -> s_ready=0 until NSYNC cycles after x_ack falls.
REQ-037 Timeout (macro on, TO_CYCLES=8), x_ack tied 0 -> err_timeout=1 and x_req=0 exactly 8 cycles after entering REQ; err_clr pulse clears err_timeout.
REQ-038 rst_n asserted during RELEASE -> x_req=0, busy=0, x_data=0 without waiting for a clk edge.
